// File: rtl/turbo_pkg.sv
// Shared constants and types for the rate-1/3 PCCC turbo encoder:
// RSC generator taps, legal block-size bounds, FSM encoding and tail layout.
package turbo_pkg;

   localparam int K_MIN = 40;
   localparam int K_MAX = 2560;

   // Taps over the RSC state vector {r1, r2, r3}
   localparam logic [2:0] FB_TAPS  = 3'b011;
   localparam logic [2:0] OUT_TAPS = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      TERM = 2'd2,
      TAIL = 2'd3
   } state_t;

   // Index i of each field holds the bit produced in termination step i
   typedef struct packed {
      logic [2:0] x1;
      logic [2:0] z1;
      logic [2:0] x2;
      logic [2:0] z2;
   } tail_t;

   function automatic logic tap_xor(input logic [2:0] st, input logic [2:0] taps);
      return ^(st & taps);
   endfunction

endpackage

// File: rtl/turbo_pccc_encoder_rsc.sv
// 8-state recursive systematic convolutional encoder (g0 = 13, g1 = 15 octal).
// In termination mode the input is replaced by the feedback so the state drains to zero.
module rsc_encoder
   import turbo_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic term,
   input  logic x,
   output logic z,
   output logic x_eff
);

   logic [2:0] st;
   logic       fb;
   logic       a;

   always_comb begin
      fb    = tap_xor(st, FB_TAPS);
      x_eff = term ? fb : x;
      a     = x_eff ^ fb;
      z     = a ^ tap_xor(st, OUT_TAPS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= '0;
      end else if (clr) begin
         st <= '0;
      end else if (en) begin
         st <= {a, st[2:1]};
      end
   end

endmodule

// File: rtl/turbo_pccc_encoder.sv
// LTE/NB-IoT rate-1/3 PCCC turbo encoder: latches a K-bit block and its interleaved copy,
// streams K systematic/parity triples, terminates both trellises and emits 4 tail triples.
module turbo_pccc_encoder
   import turbo_pkg::*;
#(
   parameter int K     = 40,
   parameter int CNT_W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [K-1:0] in_data,
   input  logic [K-1:0] intl_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         d0,
   output logic         d1,
   output logic         d2,
   output logic         out_last,
   output logic         busy
);

   if ((K % 8) != 0 || K < K_MIN || K > K_MAX) begin : g_bad_k
      $error("turbo_pccc_encoder: illegal block size K=%0d", K);
   end
   if ((64'd1 << CNT_W) <= 64'(K + 4)) begin : g_bad_cnt
      $error("turbo_pccc_encoder: CNT_W=%0d too small for K=%0d", CNT_W, K);
   end

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] k;
   logic [CNT_W-1:0] k_nxt;
   logic [K-1:0]     sys_sr;
   logic [K-1:0]     intl_sr;
   tail_t            tail;

   logic rsc_clr;
   logic rsc_en;
   logic rsc_term;
   logic z1;
   logic z2;
   logic xe1;
   logic xe2;

   rsc_encoder u_rsc1 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (rsc_clr),
      .en    (rsc_en),
      .term  (rsc_term),
      .x     (sys_sr[K-1]),
      .z     (z1),
      .x_eff (xe1)
   );

   rsc_encoder u_rsc2 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (rsc_clr),
      .en    (rsc_en),
      .term  (rsc_term),
      .x     (intl_sr[K-1]),
      .z     (z2),
      .x_eff (xe2)
   );

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      d0        = 1'b0;
      d1        = 1'b0;
      d2        = 1'b0;
      out_last  = 1'b0;
      rsc_clr   = 1'b0;
      rsc_en    = 1'b0;
      rsc_term  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ENC;
               k_nxt     = '0;
               rsc_clr   = 1'b1;
            end
         end
         ENC: begin
            out_valid = 1'b1;
            d0        = sys_sr[K-1];
            d1        = z1;
            d2        = z2;
            if (out_ready) begin
               rsc_en = 1'b1;
               if (k == CNT_W'(K - 1)) begin
                  state_nxt = TERM;
                  k_nxt     = '0;
               end else begin
                  k_nxt = k + CNT_W'(1);
               end
            end
         end
         TERM: begin
            rsc_en   = 1'b1;
            rsc_term = 1'b1;
            if (k == CNT_W'(2)) begin
               state_nxt = TAIL;
               k_nxt     = '0;
            end else begin
               k_nxt = k + CNT_W'(1);
            end
         end
         TAIL: begin
            out_valid = 1'b1;
            // Tail bit multiplexing of the three streams, encoder 1 first
            case (k[1:0])
               2'd0:    begin d0 = tail.x1[0]; d1 = tail.z1[0]; d2 = tail.x1[1]; end
               2'd1:    begin d0 = tail.z1[1]; d1 = tail.x1[2]; d2 = tail.z1[2]; end
               2'd2:    begin d0 = tail.x2[0]; d1 = tail.z2[0]; d2 = tail.x2[1]; end
               default: begin d0 = tail.z2[1]; d1 = tail.x2[2]; d2 = tail.z2[2]; end
            endcase
            out_last = (k[1:0] == 2'd3);
            if (out_ready) begin
               if (k[1:0] == 2'd3) begin
                  state_nxt = IDLE;
                  k_nxt     = '0;
               end else begin
                  k_nxt = k + CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
      end
   end

   // Block data and tail bits carry no reset; out_valid gates them until written
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         sys_sr  <= in_data;
         intl_sr <= intl_data;
      end else if (state == ENC && out_ready) begin
         sys_sr  <= sys_sr << 1;
         intl_sr <= intl_sr << 1;
      end
      if (state == TERM) begin
         tail.x1[k[1:0]] <= xe1;
         tail.z1[k[1:0]] <= z1;
         tail.x2[k[1:0]] <= xe2;
         tail.z2[k[1:0]] <= z2;
      end
   end

   assign busy = (state != IDLE);

endmodule
